integral_trigger_40mhz: RTL

INTEGRAL_TRIGGER_40MHZ -- requirements
Module: integral_trigger_40mhz

---
 rtl/integral_trigger_40mhz_pkg.sv | 28 ++
 rtl/integral_trigger_40mhz_coinc_count.sv | 30 +++
 rtl/integral_trigger_40mhz.sv | 102 ++++++++++
 3 files changed

// File: rtl/integral_trigger_40mhz_pkg.sv
// Trigger definitions: integral width, default holdoff width and FSM state encodings
// shared by the integral trigger and its coincidence counter.
`ifndef SDE_TRIGGER_DEFS_VH
`define SDE_TRIGGER_DEFS_VH
`ifndef COMPATIBILITY_INTEGRAL_BITS
`define COMPATIBILITY_INTEGRAL_BITS 12
`endif
`define SDE_HOLDOFF_BITS_DEFAULT 8
`define SDE_ST_REARM 2'd0
`define SDE_ST_ARMED 2'd1
`define SDE_ST_HOLD  2'd2
`endif

package integral_trigger_40mhz_pkg;

    localparam int INTEGRAL_BITS = `COMPATIBILITY_INTEGRAL_BITS;
    localparam int HOLDOFF_BITS_DEFAULT = `SDE_HOLDOFF_BITS_DEFAULT;

    // Phase value of ENABLE40 on which the trigger decision is taken.
    localparam logic [1:0] PHASE_EVAL = 2'd1;

    typedef enum logic [1:0] {
        ST_REARM = `SDE_ST_REARM,
        ST_ARMED = `SDE_ST_ARMED,
        ST_HOLD  = `SDE_ST_HOLD
    } trig_state_e;

endpackage

// File: rtl/integral_trigger_40mhz_coinc_count.sv
// Per-PMT threshold compare (strictly greater, unsigned, masked) and popcount of the
// resulting above-threshold pattern. Purely combinational.
import integral_trigger_40mhz_pkg::*;

module integral_coinc_count #(
    parameter int NPMT = 3,
    parameter int IW   = INTEGRAL_BITS,
    parameter int CW   = $clog2(NPMT + 1)
) (
    input  logic [NPMT*IW-1:0] integral,
    input  logic [IW-1:0]      threshold,
    input  logic [NPMT-1:0]    mask,
    output logic [NPMT-1:0]    above,
    output logic [CW-1:0]      count
);

    always_comb begin
        logic [NPMT-1:0] hit;
        logic [CW-1:0]   n;
        hit = '0;
        n   = '0;
        for (int i = 0; i < NPMT; i++) begin
            hit[i] = mask[i] && (integral[i*IW +: IW] > threshold);
            n      = n + CW'(hit[i]);
        end
        above = hit;
        count = n;
    end

endmodule

// File: rtl/integral_trigger_40mhz.sv
// Multi-PMT integral coincidence trigger running on the 120 MHz clock, deciding once
// per 40 MHz tick (ENABLE40 phase 1) and emitting a one-cycle registered pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// REARM | waiting for an evaluation with no masked PMT above threshold
// ARMED | fires when enough masked PMTs exceed threshold
// HOLD  | dead time; holdoff counter decrements once per evaluation
import integral_trigger_40mhz_pkg::*;

module integral_trigger_40mhz #(
    parameter int NPMT         = 3,
    parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEFAULT
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic [1:0]                      ENABLE40,
    input  logic [NPMT*INTEGRAL_BITS-1:0]   INTEGRAL,
    input  logic [INTEGRAL_BITS-1:0]        THRESHOLD,
    input  logic [NPMT-1:0]                 MASK,
    input  logic [1:0]                      COINC_LEVEL,
    input  logic [HOLDOFF_BITS-1:0]         HOLDOFF,
    output logic                            TRIGGER,
    output logic [NPMT-1:0]                 TRIG_PMTS,
    output logic [15:0]                     TRIG_COUNT
);

    localparam int CW = $clog2(NPMT + 1);

    trig_state_e             state_q, state_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic                    trig_q;
    logic [NPMT-1:0]         pmts_q;
    logic [15:0]             trig_count_q;

    logic [NPMT-1:0] above;
    logic [CW-1:0]   n_above;
    logic            eval;
    logic            fire;

    integral_coinc_count #(
        .NPMT (NPMT),
        .IW   (INTEGRAL_BITS),
        .CW   (CW)
    ) u_coinc (
        .integral  (INTEGRAL),
        .threshold (THRESHOLD),
        .mask      (MASK),
        .above     (above),
        .count     (n_above)
    );

    assign eval = (ENABLE40 == PHASE_EVAL);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire    = 1'b0;
        if (eval) begin
            case (state_q)
                ST_REARM: begin
                    if (n_above == '0) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (COINC_LEVEL != 2'd0 && 32'(n_above) >= 32'(COINC_LEVEL)) begin
                        fire    = 1'b1;
                        state_d = ST_HOLD;
                        hold_d  = HOLDOFF;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) state_d = ST_REARM;
                    else              hold_d  = hold_q - 1'b1;
                end
                default: state_d = ST_REARM;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_REARM;
            hold_q       <= '0;
            trig_q       <= 1'b0;
            pmts_q       <= '0;
            trig_count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= fire;
            if (fire) begin
                pmts_q <= above;
                if (trig_count_q != 16'hFFFF) trig_count_q <= trig_count_q + 16'd1;
            end
        end
    end

    assign TRIGGER    = trig_q;
    assign TRIG_PMTS  = pmts_q;
    assign TRIG_COUNT = trig_count_q;

endmodule
